ps2_rx_fifo: RTL and testbench

//  Oversampled PS/2 device-to-host receiver running entirely in the system clock domain.

---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_byte_fifo.sv | 56 +++++
 rtl/ps2_rx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 framing constants, receiver FSM states and the parity helper.
package ps2_pkg;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ps2_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic par);
    return ^{d, par};
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Show-ahead byte FIFO: head byte is always visible on o_dout, pop advances it.
// Push is accepted when not full, or when full and a pop happens in the same cycle.
module ps2_byte_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [7:0]             i_din,
  input  logic                   i_pop,
  output logic [7:0]             o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rptr];
  assign o_count   = r_count;

  // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// Oversampled PS/2 device-to-host receiver: synchronise and glitch-filter the pins,
// frame 11-bit packets, recover from stalled frames and buffer good bytes in a FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYC    = 50000,
  parameter int DROP_ON_PARITY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps2Clk,
  input  logic                   ps2Dat,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [7:0]             data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_filt, r_filt_d;
  logic [FW-1:0]          r_filt_cnt;
  logic                   w_clk_s, w_sample, w_strobe;

  ps2_state_t             r_state, w_state_n;
  logic [3:0]             r_bitcnt, w_bitcnt_n;
  logic [8:0]             r_shift, w_shift_n;
  logic [TW-1:0]          r_to_cnt, w_to_n;
  logic                   w_timeout;

  logic                   w_stop, w_par_ok, w_frame_evt, w_par_evt, w_push_req;
  logic                   r_push;
  logic [7:0]             r_push_data;
  logic                   r_parity_err, r_frame_err, r_overflow;

  logic                   w_pop, w_full, w_empty, w_ovf_evt;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_sample = r_dat_sync[SYNC_STAGES-1];
  assign w_strobe = r_filt_d & ~r_filt;

  // Two-pin synchroniser chains, idle-high after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2Clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2Dat};
    end
  end

  // Clock filter: flip the level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (w_clk_s == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // A stalled partial frame expires once the counter would reach TIMEOUT_CYC
  assign w_timeout = (r_state == SHIFT) && !w_strobe && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  // FSM state register with bit counter, shifter and timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift  <= w_shift_n;
      r_to_cnt <= w_to_n;
    end
  end

  // FSM next state: start bit opens a frame, stop strobe or timeout closes it
  always_comb begin
    w_state_n  = r_state;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_to_n     = '0;
    case (r_state)
      IDLE: begin
        if (w_strobe && (w_sample == START_BIT)) begin
          w_state_n  = SHIFT;
          w_bitcnt_n = 4'd1;
        end
      end
      SHIFT: begin
        if (w_strobe) begin
          if (r_bitcnt == 4'(FRAME_BITS - 1)) begin
            w_state_n  = IDLE;
            w_bitcnt_n = '0;
          end else begin
            w_shift_n  = {w_sample, r_shift[8:1]};
            w_bitcnt_n = r_bitcnt + 1'b1;
          end
        end else if (w_timeout) begin
          w_state_n  = IDLE;
          w_bitcnt_n = '0;
        end else begin
          w_to_n = r_to_cnt + 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // FSM outputs: frame verdict on the stop strobe, error events and push request
  always_comb begin
    w_stop      = (r_state == SHIFT) && w_strobe && (r_bitcnt == 4'(FRAME_BITS - 1));
    w_par_ok    = odd_parity_ok(r_shift[7:0], r_shift[8]);
    w_frame_evt = (w_stop && (w_sample != STOP_BIT)) || w_timeout;
    w_par_evt   = w_stop && (w_sample == STOP_BIT) && !w_par_ok;
    w_push_req  = w_stop && (w_sample == STOP_BIT) && (w_par_ok || (DROP_ON_PARITY == 0));
  end

  // Register the push so the FIFO write lands one edge after the stop strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
    end else begin
      r_push      <= w_push_req;
      r_push_data <= r_shift[7:0];
    end
  end

  assign w_pop     = rd_en && !w_empty;
  assign w_ovf_evt = r_push && w_full && !w_pop;

  ps2_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push),
    .i_din   (r_push_data),
    .i_pop   (w_pop),
    .o_dout  (data),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky flags: a new event beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= w_par_evt   | (r_parity_err & ~clr_err);
      r_frame_err  <= w_frame_evt | (r_frame_err  & ~clr_err);
      r_overflow   <= w_ovf_evt   | (r_overflow   & ~clr_err);
    end
  end

  assign valid      = !w_empty;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a PS/2 frame driver plus a scoreboard monitor that
// checks every popped byte against the queue of bytes expected to be stored.
module tb_ps2_rx_fifo;

  localparam int HALF = 200;   // half PS/2 bit period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Dat = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [3:0] count;
  logic       parity_err, frame_err, overflow;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb[$];

  ps2_rx_fifo #(
    .DEPTH(8), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(2000), .DROP_ON_PARITY(1)
  ) dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Dat(ps2Dat), .rd_en(rd_en),
    .clr_err(clr_err), .data(data), .valid(valid), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected byte
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset && rd_en && valid) begin
        if (sb.size() == 0) chk("sb_unexpected_pop", {24'd0, data}, 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("pop_data", {24'd0, data}, {24'd0, e});
        end
      end
    end
  end

  // One PS/2 bit; pop_stop lines rd_en up with the cycle the stop-bit push reaches the FIFO
  task automatic ps2_bit(input logic b, input bit pop_stop);
    @(negedge clk); ps2Dat = b;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    if (pop_stop) begin
      repeat (7) @(posedge clk);
      #1; chk("full_pre_cnt", count, 8); rd_en = 1'b1;
      @(posedge clk); #1; rd_en = 1'b0;
      chk("full_same_cnt", count, 8); chk("full_same_ovf", overflow, 0);
      @(posedge clk); #1;
      chk("full_after_cnt", count, 8); chk("full_after_ovf", overflow, 0);
      repeat (HALF - 10) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                            input int nbits, input bit pop_stop);
    logic [10:0] fr;
    fr = {stop, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], pop_stop && (i == 10));
    repeat (20) @(negedge clk);
  endtask

  task automatic pop1();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
  endtask

  task automatic clear_flags();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_data", data, 8'h00);  chk("rst_valid", valid, 0); chk("rst_count", count, 0);
    chk("rst_perr", parity_err, 0); chk("rst_ferr", frame_err, 0); chk("rst_ovf", overflow, 0);

    // 1: good frame, then pop
    sb.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("t1_valid", valid, 1); chk("t1_data", data, 8'h1C); chk("t1_count", count, 1);
    pop1();
    chk("t1_pop_valid", valid, 0); chk("t1_pop_count", count, 0);

    // 2: parity error dropped, flag cleared by clr_err
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
    chk("t2_perr", parity_err, 1); chk("t2_count", count, 0); chk("t2_ferr", frame_err, 0);
    clear_flags();
    chk("t2_clr", parity_err, 0);

    // 3: overflow, then same-cycle push+pop while full, then drain in order
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) sb.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0);
    end
    chk("t3_count", count, 8); chk("t3_ovf", overflow, 1); chk("t3_head", data, 8'h01);
    clear_flags();
    chk("t3_ovf_clr", overflow, 0);
    sb.push_back(8'h0A);
    send_frame(8'h0A, 1'b0, 1'b1, 11, 1'b1);
    chk("t3_full_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) pop1();
    chk("t3_drained_cnt", count, 0); chk("t3_drained_valid", valid, 0);
    pop1();
    chk("t3_empty_rd_cnt", count, 0); chk("t3_empty_rd_valid", valid, 0);

    // 4: partial frame times out, next frame intact
    send_frame(8'hA5, 1'b0, 1'b1, 6, 1'b0);
    repeat (1680) @(negedge clk);
    chk("t4_ferr_early", frame_err, 0);
    repeat (250) @(negedge clk);
    chk("t4_ferr_timeout", frame_err, 1); chk("t4_count", count, 0);
    clear_flags();
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
    chk("t4_data", data, 8'h5A); chk("t4_count2", count, 1); chk("t4_ferr2", frame_err, 0);
    pop1();

    // 5: short low glitch with data low must not open a frame
    @(negedge clk); ps2Dat = 1'b0; ps2Clk = 1'b0;
    repeat (2) @(negedge clk); ps2Clk = 1'b1;
    repeat (10) @(negedge clk); ps2Dat = 1'b1;
    repeat (2100) @(negedge clk);
    chk("t5_glitch_ferr", frame_err, 0); chk("t5_glitch_cnt", count, 0);
    sb.push_back(8'h44);
    send_frame(8'h44, 1'b0, 1'b1, 11, 1'b0);
    chk("t5_data", data, 8'h44); chk("t5_count", count, 1);
    send_frame(8'h33, 1'b0, 1'b0, 11, 1'b0);
    chk("t5_stop_ferr", frame_err, 1); chk("t5_stop_cnt", count, 1); chk("t5_stop_head", data, 8'h44);

    // 6: reset mid-frame clears everything; next frame received
    send_frame(8'h77, 1'b0, 1'b1, 6, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t6_data", data, 8'h00); chk("t6_valid", valid, 0); chk("t6_count", count, 0);
    chk("t6_ferr", frame_err, 0); chk("t6_perr", parity_err, 0); chk("t6_ovf", overflow, 0);
    sb.push_back(8'h29);
    send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
    chk("t6_rx_data", data, 8'h29); chk("t6_rx_count", count, 1); chk("t6_rx_ferr", frame_err, 0);
    pop1();
    chk("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
